// File: rtl/addsub_serial_n_if.sv
// rtl/addsub_serial_n_if.sv - operand/result handshake bundle for the serial add/sub unit
interface addsub_serial_n_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, sat, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, op, sat, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );
endinterface

// File: rtl/addsub_serial_n.sv
// rtl/addsub_serial_n.sv - chunk-serial adder/subtractor with optional signed saturation
module addsub_serial_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_serial_n_if.slave   bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] CMASK   = WIDTH'({CHUNK{1'b1}});
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             sat_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;

    logic             last;
    logic [31:0]      shamt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK:0]   sum;
    logic             msb_cin;
    logic             ovf_raw;
    logic [WIDTH-1:0] merged;

    assign last = (cnt_q == CW'(NCH - 1));

    // One CHUNK+1 bit adder slice; the chunk is selected by shifting the latched operands.
    always_comb begin
        shamt   = 32'(cnt_q) * 32'(CHUNK);
        a_sh    = a_q >> shamt;
        b_sh    = b_q >> shamt;
        sum     = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        msb_cin = sum[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
        ovf_raw = msb_cin ^ sum[CHUNK];
        merged  = (result_q & ~(CMASK << shamt)) | (WIDTH'(sum[CHUNK-1:0]) << shamt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sat_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.op ? ~bus.b : bus.b;
                        sat_q   <= bus.sat;
                        carry_q <= bus.op;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    result_q <= merged;
                    carry_q  <= sum[CHUNK];
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        cout_q <= sum[CHUNK];
                        ovf_q  <= ovf_raw;
                        if (sat_q && ovf_raw) begin
                            result_q <= a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_addsub_serial_n.sv
// tb/tb_addsub_serial_n.sv - scoreboard bench for addsub_serial_n against an arithmetic model
module tb_addsub_serial_n;
    localparam int W   = 16;
    localparam int C   = 4;
    localparam int NCH = W / C;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];

    addsub_serial_n_if #(.WIDTH(W)) bus ();

    addsub_serial_n #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic op, input logic sat);
        exp_t   e;
        longint ua, ub, sa, sb, r, maxv, minv;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (64'sd1 <<< (W - 1)) - 1;
        minv = -(64'sd1 <<< (W - 1));
        r    = op ? sa - sb : sa + sb;
        e.co = op ? (ua >= ub) : ((ua + ub) >= (64'sd1 <<< W));
        e.ov = (r > maxv) || (r < minv);
        e.res = r[W-1:0];
        if (sat && e.ov) e.res = (r > maxv) ? maxv[W-1:0] : minv[W-1:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", 64'(bus.result), 64'hDEAD);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("cout", 64'(bus.cout), 64'(e.co));
                check("overflow", 64'(bus.overflow), 64'(e.ov));
            end
        end
    end

    task automatic send(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic op_v, input logic sat_v, input int hold);
        int           n;
        logic [W-1:0] r0;
        logic         c0, o0;
        bus.a = a_v; bus.b = b_v; bus.op = op_v; bus.sat = sat_v; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
        sbq.push_back(model(a_v, b_v, op_v, sat_v));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom); bus.sat = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'(NCH));
        r0 = bus.result; c0 = bus.cout; o0 = bus.overflow;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_stable", 64'({bus.result, bus.cout, bus.overflow}), 64'({r0, c0, o0}));
        end
        bus.out_ready = 1'b1;
        if (hold > 0) bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        if (hold > 0) begin
            check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
            check("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.sat = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_outputs", 64'({bus.result, bus.cout, bus.overflow}), 64'd0);

        send(16'h0005, 16'h0003, 1'b1, 1'b0, 0);
        send(16'h0003, 16'h0005, 1'b1, 1'b0, 0);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 3);

        // Abort mid-operation: the pending expectation is withdrawn.
        bus.a = 16'h1234; bus.b = 16'h4321; bus.op = 1'b0; bus.sat = 1'b0; bus.in_valid = 1'b1;
        sbq.push_back(model(16'h1234, 16'h4321, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(sbq.pop_back());
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) n++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", 64'(n), 64'd0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 4) == 0) ra = {1'($urandom), {(W-1){ra[0]}}};
            send(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/addsub_serial_n.md
ADDSUB_SERIAL_N -- requirements
Module: addsub_serial_n

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal values are 4 to 64.
REQ-002 Parameter CHUNK, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend or augend.
- b  in  WIDTH  subtrahend or addend.
- op  in  1  0 = a+b, 1 = a-b.
- sat  in  1  1 = saturate on signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum or difference.
- cout  out  1  raw carry out of the MSB (for sub, 1 = no unsigned borrow, i.e. a >= b).
- overflow  out  1  two's-complement signed overflow.

Function
REQ-005 The block SHALL have three states: IDLE, BUSY and DONE.
REQ-006 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-007 Accept SHALL occur on an edge where in_valid && in_ready. On accept the block SHALL:
- latch a;
- latch b, or ~b when op = 1;
- latch sat and op;
- set the carry-in to op;
- clear the chunk counter;
- go to BUSY.
REQ-008 In BUSY, each edge SHALL add chunk k of the latched operands (LSB chunk first) plus the running carry, and write it into result bits [k*CHUNK+CHUNK-1 : k*CHUNK]; the counter SHALL increment, and NCH edges complete the operation.
REQ-009 On the edge that processes chunk NCH-1, the block SHALL go to DONE, capture cout as the MSB carry-out, and capture overflow as (carry into MSB) XOR (carry out of MSB).
REQ-010 Latency: out_valid SHALL first be visible NCH cycles after the accept edge; with CHUNK = WIDTH this is 1 cycle.
REQ-011 Saturation: when the latched sat = 1 and overflow = 1, result SHALL be replaced in the same edge by:
- 0111...1 if the latched a MSB = 0;
- 1000...0 if the latched a MSB = 1.
cout and overflow SHALL still report the raw values.
REQ-012 In DONE, result, cout and overflow SHALL hold stable while out_ready = 0, for any number of cycles.
REQ-013 DONE && out_ready SHALL move the block to IDLE on that edge.
REQ-014 New operands SHALL NOT be accepted in the same edge as a result handshake; the earliest next accept is one cycle later.
REQ-015 in_valid, a, b, op and sat SHALL be ignored outside IDLE; input changes during BUSY SHALL NOT affect the result.
REQ-016 result, cout and overflow SHALL hold their last values in IDLE and BUSY. Their value is don't-care to the consumer unless out_valid = 1, but they SHALL NOT be X after reset.
REQ-017 Width rule: the internal carry path SHALL be CHUNK+1 bits per cycle; no WIDTH+1-bit adder SHALL be instantiated when CHUNK < WIDTH.
REQ-018 The block SHALL be fully synchronous, with no combinational path from in_valid or out_ready to any output.

Reset
REQ-019 While rst_n = 0 at an edge, the block SHALL set:
- state = IDLE;
- chunk counter = 0;
- result = 0, cout = 0, overflow = 0;
- out_valid = 0;
- in_ready = 1 from the first cycle after reset.
REQ-020 Reset in BUSY or DONE SHALL abort the operation. No out_valid SHALL be produced for the aborted operands, and the next accept SHALL start from a clean carry and counter.

Verification
REQ-021 WIDTH=16, CHUNK=4: op=1, a=0x0005, b=0x0003 -> out_valid 4 cycles after accept; result=0x0002, cout=1, overflow=0.
REQ-022 op=1, a=0x0003, b=0x0005 -> result=0xFFFE, cout=0, overflow=0.
REQ-023 op=1, a=0x8000, b=0x0001:
- sat=0 -> result=0x7FFF, cout=1, overflow=1;
- sat=1 -> result=0x8000, overflow=1.
REQ-024 op=0, a=0x7FFF, b=0x0001:
- sat=0 -> result=0x8000, cout=0, overflow=1;
- sat=1 -> result=0x7FFF.
REQ-025 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid, a and b. Required response: result, cout and overflow stable; in_ready=0; nothing accepted. On out_ready=1 -> IDLE next cycle, and an accept is possible one cycle later.
REQ-026 Assert rst_n=0 for one edge after 2 BUSY cycles -> out_valid never rises for those operands; in_ready=1 the next cycle; a following op=0, 0x0001+0x0001 yields 0x0002.
